sliced_adder_seq: RTL

Parametrised multi-cycle adder and the sequential successor of the combinational full adder and 8-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, SLICE bits per clock, LSB slice first.
- Carry is held in a register between slices.
- Used where area matters more than latency; a START/BUSY/DONE handshake lets a controller or bench sequence operations.

---
 rtl/sliced_adder_seq_if.sv | 42 ++++
 rtl/sliced_adder_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sliced_adder_seq_if.sv
// sliced_adder_seq_if: handshake and data bundle for sliced_adder_seq.
//   master : controller side; drives start/a/b/cin (and sub) and observes results
//   slave  : adder side; samples operands and drives busy/done/sum/cout/ovf
// Signals:
//   start        request a new operation (honoured only when not busy)
//   a, b         WIDTH-bit operands, cin carry-in
//   sub          subtract select (only when SLICED_ADDER_SUB_EN is defined)
//   busy         slices are being processed
//   done         one-cycle pulse, results valid from this cycle on
//   sum/cout/ovf registered result, carry out of the MSB, signed overflow
interface sliced_adder_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SLICED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef SLICED_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
`ifdef SLICED_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/sliced_adder_seq.sv
// sliced_adder_seq: multi-cycle adder that processes SLICE bits per clock,
// least significant slice first, keeping the carry in a register between
// slices. {cout, sum} = a + b + cin; ovf = carry into MSB ^ carry out of MSB.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, highest priority
//   bus  sliced_adder_seq_if.slave (start/a/b/cin[/sub] in, busy/done/sum/cout/ovf out)
// Parameters: WIDTH (>= 2) operand width, SLICE bits per cycle (must divide WIDTH).
// Optional feature: define SLICED_ADDER_SUB_EN to add the sub input; with sub = 1
// the adder computes a - b - cin (cout = 1 means no borrow).
// Timing: start accepted at edge 0, slices processed on edges 1..N (N = WIDTH/SLICE),
// done high in the cycle after edge N. A start seen in FIN restarts immediately.
module sliced_adder_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic                clk,
  input  logic                rst,
  sliced_adder_seq_if.slave   bus
);
  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;        // already inverted for subtraction
  logic [WIDTH-1:0] res_reg;      // slice results accumulate here
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Operand registers viewed as arrays of slices so the active slice is a
  // plain array read indexed by the counter.
  logic [SLICE-1:0] a_sl [N];
  logic [SLICE-1:0] b_sl [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  logic [SLICE-1:0] a_cur;
  logic [SLICE-1:0] b_cur;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] res_next;
  logic             carry_into_msb;

  always_comb begin
    a_cur     = a_sl[cnt_reg];
    b_cur     = b_sl[cnt_reg];
    slice_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{SLICE{1'b0}}, carry_reg};
    res_next  = res_reg;
    res_next[cnt_reg*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    // Carry into the top bit of this slice, recovered from its sum bit.
    // Only meaningful on the last slice, where that bit is the word MSB.
    carry_into_msb = a_cur[SLICE-1] ^ b_cur[SLICE-1] ^ slice_sum[SLICE-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, FIN: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg <= bus.a;
`ifdef SLICED_ADDER_SUB_EN
            // a - b - cin = a + ~b + ~cin
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.cin ^ bus.sub;
`else
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
`endif
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          res_reg   <= res_next;
          carry_reg <= slice_sum[SLICE];
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            sum_reg   <= res_next;
            cout_reg  <= slice_sum[SLICE];
            ovf_reg   <= slice_sum[SLICE] ^ carry_into_msb;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= FIN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
endmodule
